// File: rtl/mc_datapath_hs.sv
// Multicycle MIPS datapath with a memory-ready handshake: every register
// holds while the controller's memory access is still outstanding.
module mc_datapath_hs #(
  parameter int               WIDTH    = 32,
  parameter int               REGBITS  = 5,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] memdata,
  input  logic             memready,
  input  logic             memaccess,
  input  logic             alusrca,
  input  logic             iord,
  input  logic             pcen,
  input  logic             irwrite,
  input  logic             regwrite,
  input  logic             extop,
  input  logic [1:0]       memtoreg,
  input  logic [1:0]       regdst,
  input  logic [1:0]       pcsource,
  input  logic [1:0]       alusrcb,
  input  logic [2:0]       alucont,
  output logic             stall,
  output logic             zero,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata
);

  localparam int               SHW  = $clog2(WIDTH);
  localparam int               NREG = 2 ** REGBITS;
  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

  logic [WIDTH-1:0]   pc, mdr, a, b, aluout;
  logic [31:0]        ir;
  logic [WIDTH-1:0]   regs [NREG];

  logic               adv;
  logic [REGBITS-1:0] rs, rt, rd, wa;
  logic [WIDTH-1:0]   rd1, rd2, wd;
  logic [15:0]        imm;
  logic [WIDTH-1:0]   imm_sext, imm_zext, ext_imm, lui_imm, br_off;
  logic [WIDTH-1:0]   src1, src2, aluresult, pc_plus4, nextpc;
  logic [SHW-1:0]     shamt;

  assign stall = memaccess & ~memready;
  assign adv   = ~stall;

  assign rs = ir[21 +: REGBITS];
  assign rt = ir[16 +: REGBITS];
  assign rd = ir[11 +: REGBITS];

  // Register 0 is never written, so a plain array read already returns 0 for it.
  assign rd1 = regs[rs];
  assign rd2 = regs[rt];

  assign imm      = ir[15:0];
  assign imm_sext = {{(WIDTH-16){imm[15]}}, imm};
  assign imm_zext = {{(WIDTH-16){1'b0}}, imm};
  assign ext_imm  = extop ? imm_zext : imm_sext;
  assign lui_imm  = imm_zext << 16;
  assign br_off   = imm_sext << 2;

  assign src1     = alusrca ? a : pc;
  assign shamt    = src2[SHW-1:0];
  assign pc_plus4 = pc + FOUR;

  always_comb begin
    src2 = b;
    case (alusrcb)
      2'b00:   src2 = b;
      2'b01:   src2 = FOUR;
      2'b10:   src2 = ext_imm;
      default: src2 = alusrca ? lui_imm : br_off;
    endcase
  end

  always_comb begin
    aluresult = '0;
    case (alucont)
      3'b000:  aluresult = src1 & src2;
      3'b001:  aluresult = src1 | src2;
      3'b010:  aluresult = src1 + src2;
      3'b110:  aluresult = src1 - src2;
      3'b111:  aluresult[0] = $signed(src1) < $signed(src2);
      3'b100:  aluresult = src1 ^ src2;
      3'b101:  aluresult = ~(src1 | src2);
      default: aluresult = src1 << shamt;
    endcase
  end

  always_comb begin
    wa = rt;
    case (regdst)
      2'b01:   wa = rd;
      2'b10:   wa = '1;
      default: wa = rt;
    endcase
  end

  always_comb begin
    wd = aluout;
    case (memtoreg)
      2'b01:   wd = mdr;
      2'b10:   wd = pc_plus4;
      default: wd = aluout;
    endcase
  end

  always_comb begin
    nextpc = pc_plus4;
    case (pcsource)
      2'b00:   nextpc = pc_plus4;
      2'b01:   nextpc = aluout;
      2'b10:   nextpc = {pc[WIDTH-1:28], ir[25:0], 2'b00};
      default: nextpc = a;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      ir     <= '0;
      mdr    <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
    end else begin
      if (pcen && adv)           pc  <= nextpc;
      if (irwrite && adv)        ir  <= memdata[31:0];
      if (memaccess && memready) mdr <= memdata;
      if (adv) begin
        a      <= rd1;
        b      <= rd2;
        aluout <= aluresult;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (regwrite && adv && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign zero      = (aluresult == '0);
  assign adr       = iord ? aluout : pc;
  assign writedata = b;
  assign instr     = ir;

endmodule

// File: tb/tb_mc_datapath_hs.sv
// Self-checking bench for mc_datapath_hs: directed scenarios plus random
// control sequences, all compared against an architectural reference model.
module tb_mc_datapath_hs;

  localparam int          WIDTH    = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] memdata;
  logic        memready, memaccess, alusrca, iord, pcen, irwrite, regwrite, extop;
  logic [1:0]  memtoreg, regdst, pcsource, alusrcb;
  logic [2:0]  alucont;
  logic        stall, zero;
  logic [31:0] instr, adr, writedata;

  int check_count = 0;
  int fail_count  = 0;

  // Architectural state of the reference model
  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;
  logic [31:0] m_regs [32];

  always #5 clk = ~clk;

  mc_datapath_hs #(.WIDTH(WIDTH), .REGBITS(5), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .memdata(memdata), .memready(memready),
    .memaccess(memaccess), .alusrca(alusrca), .iord(iord), .pcen(pcen),
    .irwrite(irwrite), .regwrite(regwrite), .extop(extop), .memtoreg(memtoreg),
    .regdst(regdst), .pcsource(pcsource), .alusrcb(alusrcb), .alucont(alucont),
    .stall(stall), .zero(zero), .instr(instr), .adr(adr), .writedata(writedata)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_pc = RESET_PC;
    m_ir = '0; m_mdr = '0; m_a = '0; m_b = '0; m_aluout = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  endtask

  task automatic idle();
    memdata = '0; memready = 0; memaccess = 0; alusrca = 0; iord = 0; pcen = 0;
    irwrite = 0; regwrite = 0; extop = 0; memtoreg = 0; regdst = 0; pcsource = 0;
    alusrcb = 0; alucont = 0;
  endtask

  task automatic doReset();
    idle();
    reset = 1;
    #1;
    modelReset();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  // One clock with the current inputs: compare outputs, then advance the model.
  task automatic applyStimulus();
    logic [31:0] rd1, rd2, imm_s, imm_z, s1, s2, res, pc4, npc, wd, mem_now;
    int rs, rt, rd, wa;
    bit adv;
    #1;
    adv   = !(memaccess && !memready);
    rs    = int'(m_ir[25:21]);
    rt    = int'(m_ir[20:16]);
    rd    = int'(m_ir[15:11]);
    rd1   = m_regs[rs];
    rd2   = m_regs[rt];
    imm_s = {{16{m_ir[15]}}, m_ir[15:0]};
    imm_z = {16'h0000, m_ir[15:0]};
    s1    = alusrca ? m_a : m_pc;
    case (alusrcb)
      2'd0:    s2 = m_b;
      2'd1:    s2 = 32'd4;
      2'd2:    s2 = extop ? imm_z : imm_s;
      default: s2 = alusrca ? (imm_z << 16) : (imm_s << 2);
    endcase
    case (alucont)
      3'b000:  res = s1 & s2;
      3'b001:  res = s1 | s2;
      3'b010:  res = s1 + s2;
      3'b110:  res = s1 - s2;
      3'b111:  res = ($signed(s1) < $signed(s2)) ? 32'd1 : 32'd0;
      3'b100:  res = s1 ^ s2;
      3'b101:  res = ~(s1 | s2);
      default: res = s1 << s2[4:0];
    endcase
    pc4 = m_pc + 32'd4;
    case (pcsource)
      2'd0:    npc = pc4;
      2'd1:    npc = m_aluout;
      2'd2:    npc = {m_pc[31:28], m_ir[25:0], 2'b00};
      default: npc = m_a;
    endcase
    case (regdst)
      2'd1:    wa = rd;
      2'd2:    wa = 31;
      default: wa = rt;
    endcase
    case (memtoreg)
      2'd1:    wd = m_mdr;
      2'd2:    wd = pc4;
      default: wd = m_aluout;
    endcase
    mem_now = memdata;
    checkOutput("stall", 64'(stall), 64'(!adv));
    checkOutput("zero", 64'(zero), 64'(res == 0));
    checkOutput("adr", 64'(adr), 64'(iord ? m_aluout : m_pc));
    checkOutput("instr", 64'(instr), 64'(m_ir));
    checkOutput("writedata", 64'(writedata), 64'(m_b));
    @(posedge clk);
    if (memaccess && memready) m_mdr = mem_now;
    if (adv) begin
      if (pcen) m_pc = npc;
      if (irwrite) m_ir = mem_now;
      if (regwrite && wa != 0) m_regs[wa] = wd;
      m_a = rd1; m_b = rd2; m_aluout = res;
    end
    #1;
  endtask

  task automatic fetch(input logic [31:0] word);
    idle();
    memdata = word; memaccess = 1; memready = 1; irwrite = 1; pcen = 1;
    alusrcb = 2'b01; alucont = 3'b010;
    applyStimulus();
    idle();
  endtask

  // Load into rt of the current IR: read completes, then write-back from MDR.
  task automatic loadReg(input logic [31:0] value);
    idle();
    memaccess = 1; memready = 1; memdata = value;
    applyStimulus();
    idle();
    memdata = ~value; memtoreg = 2'b01; regwrite = 1;
    applyStimulus();
    idle();
  endtask

  task automatic execAndCheck(input string tag, input logic x_extop,
                              input logic [1:0] x_srcb, input logic [2:0] x_op,
                              input logic [31:0] expected);
    idle();
    alusrca = 1; extop = x_extop; alusrcb = x_srcb; alucont = x_op;
    applyStimulus();
    idle();
    iord = 1;
    #1;
    checkOutput(tag, 64'(adr), 64'(expected));
    iord = 0;
  endtask

  task automatic decodeAndCheckB(input string tag, input logic [31:0] expected);
    idle();
    applyStimulus();
    checkOutput(tag, 64'(writedata), 64'(expected));
  endtask

  initial begin
    idle();
    doReset();
    #1;
    checkOutput("reset_adr", 64'(adr), 64'(32'h40));
    checkOutput("reset_instr", 64'(instr), 64'(0));
    checkOutput("reset_writedata", 64'(writedata), 64'(0));
    checkOutput("reset_stall", 64'(stall), 64'(0));

    // Fetch held off by three not-ready cycles
    memdata = 32'h2008_FFFF; memaccess = 1; memready = 0; irwrite = 1; pcen = 1;
    alusrcb = 2'b01; alucont = 3'b010;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("stall_instr", 64'(instr), 64'(0));
      checkOutput("stall_pc", 64'(adr), 64'(32'h40));
    end
    memready = 1;
    applyStimulus();
    idle();
    #1;
    checkOutput("fetch_instr", 64'(instr), 64'(32'h2008_FFFF));
    checkOutput("fetch_pc", 64'(adr), 64'(32'h44));

    // addi / ori with A = 5
    loadReg(32'd5);
    fetch(32'h2108_FFFF);
    decodeAndCheckB("r8_value", 32'd5);
    execAndCheck("addi_wrap", 1'b0, 2'b10, 3'b010, 32'd4);
    execAndCheck("ori_zext", 1'b1, 2'b10, 3'b010, 32'h0001_0004);

    // lui, write r1, attempted write to r0
    fetch(32'h3C01_1234);
    decodeAndCheckB("lui_decode", 32'd0);
    execAndCheck("lui_result", 1'b0, 2'b11, 3'b001, 32'h1234_0000);
    regwrite = 1;
    applyStimulus();
    idle();
    fetch(32'h3C20_0000);
    regwrite = 1;
    applyStimulus();
    decodeAndCheckB("r0_still_zero", 32'd0);
    fetch(32'h0001_0000);
    decodeAndCheckB("r1_lui", 32'h1234_0000);

    // jal from PC 0x44
    doReset();
    fetch(32'h0C00_0010);
    pcen = 1; pcsource = 2'b10; regdst = 2'b10; memtoreg = 2'b10; regwrite = 1;
    applyStimulus();
    idle();
    #1;
    checkOutput("jal_pc", 64'(adr), 64'(32'h40));
    fetch(32'h001F_0000);
    decodeAndCheckB("jal_r31", 32'h48);

    // lw timing: MDR from the ready cycle, not the write-back cycle
    loadReg(32'hDEAD_BEEF);
    decodeAndCheckB("lw_r31", 32'hDEAD_BEEF);

    // SLL 1 by 31 and signed SLT(-1, 1)
    loadReg(32'd1);
    fetch(32'h03E0_001F);
    decodeAndCheckB("sll_decode", 32'd0);
    execAndCheck("sll_31", 1'b1, 2'b10, 3'b011, 32'h8000_0000);
    fetch(32'h001F_0000);
    loadReg(32'hFFFF_FFFF);
    fetch(32'h03E0_0001);
    decodeAndCheckB("slt_decode", 32'd0);
    execAndCheck("slt_signed", 1'b0, 2'b10, 3'b111, 32'd1);

    // Reset arriving in the middle of a stall
    memdata = 32'h1234_5678; memaccess = 1; memready = 0; irwrite = 1; pcen = 1;
    applyStimulus();
    #2;
    reset = 1;
    #1;
    modelReset();
    checkOutput("midstall_adr", 64'(adr), 64'(32'h40));
    checkOutput("midstall_instr", 64'(instr), 64'(0));
    checkOutput("midstall_stall", 64'(stall), 64'(1));
    @(posedge clk);
    #1;
    reset = 0;
    idle();

    // Random control sequences against the model
    for (int n = 0; n < 400; n++) begin
      memdata   = $urandom;
      memaccess = 1'($urandom_range(0, 1));
      memready  = ($urandom_range(0, 3) != 0);
      alusrca   = 1'($urandom_range(0, 1));
      iord      = 1'($urandom_range(0, 1));
      pcen      = 1'($urandom_range(0, 1));
      irwrite   = 1'($urandom_range(0, 1));
      regwrite  = 1'($urandom_range(0, 1));
      extop     = 1'($urandom_range(0, 1));
      memtoreg  = 2'($urandom_range(0, 3));
      regdst    = 2'($urandom_range(0, 3));
      pcsource  = 2'($urandom_range(0, 3));
      alusrcb   = 2'($urandom_range(0, 3));
      alucont   = 3'($urandom_range(0, 7));
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
